mrnaiso_ctl_sequencer: RTL and testbench



---
 rtl/mrnaiso_ctl_pkg.sv | 79 +++++++
 rtl/mrnaiso_ctl_sequencer_if.sv | 45 ++++
 rtl/mrnaiso_pump_seq.sv | 53 +++++
 rtl/mrnaiso_ctl_sequencer.sv | 133 +++++++++++++
 tb/tb_mrnaiso_ctl_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mrnaiso_ctl_pkg.sv
// Shared types and constants for the mRNA isolation valve sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: phase codes, the 22-line control bundle, the all-closed value,
// the peristaltic pump step pattern, and the per-phase control decode.
package mrnaiso_ctl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_LYSE    = 3'd2,
        PH_BIND    = 3'd3,
        PH_SEP     = 3'd4,
        PH_COLLECT = 3'd5,
        PH_DONE    = 3'd6
    } phase_e;

    // All valve control lines except the pump; 1 = pressurised = valve closed.
    typedef struct packed {
        logic [3:0] cells_in;
        logic [3:0] cells_out;
        logic [3:0] collect;
        logic       lysis_in;
        logic       lysis_waste;
        logic [1:0] beads_in;
        logic       bead_waste;
        logic       push;
        logic       sep;
        logic [1:0] sieve;
        logic       waste;
    } ctl_t;

    localparam ctl_t       CTL_ALL_CLOSED = '1;
    localparam logic [2:0] PUMP_IDLE      = 3'b111;
    localparam int         PUMP_STEPS     = 6;
    localparam logic [2:0] PUMP_PATTERN [0:PUMP_STEPS-1] =
        '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    // Valve levels for a phase given the latched stage mask. Any line not
    // opened by the phase stays closed.
    function automatic ctl_t ctl_decode(phase_e ph, logic [3:0] en);
        ctl_t c;
        logic pair_a;
        logic pair_b;
        c      = CTL_ALL_CLOSED;
        pair_a = en[0] | en[1];
        pair_b = en[2] | en[3];
        case (ph)
            PH_LOAD: begin
                c.cells_in = ~en;
                c.waste    = 1'b0;
            end
            PH_LYSE: begin
                c.lysis_in    = 1'b0;
                c.lysis_waste = 1'b0;
                c.cells_out   = ~en;
            end
            PH_BIND: begin
                c.beads_in = {~pair_b, ~pair_a};
                c.sieve    = 2'b11;
            end
            PH_SEP: begin
                c.sep   = 1'b0;
                c.push  = 1'b0;
                c.waste = 1'b0;
                c.sieve = 2'b11;
            end
            PH_COLLECT: begin
                c.collect    = ~en;
                c.sieve      = {~pair_b, ~pair_a};
                c.push       = 1'b0;
                c.bead_waste = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mrnaiso_ctl_sequencer_if.sv
// Control/status bundle between the protocol host and the valve sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled in IDLE.
// Ports: host drives start/abort/stage_en; the sequencer drives status
// (busy/done/aborted/phase) and every valve control line.
interface mrnaiso_ctl_sequencer_if;
    import mrnaiso_ctl_pkg::*;

    logic       start;
    logic       abort;
    logic [3:0] stage_en;
    logic       busy;
    logic       done;
    logic       aborted;
    phase_e     phase;
    logic [3:0] cells_in_ctl;
    logic [3:0] cells_out_ctl;
    logic [3:0] collect_ctl;
    logic       lysis_in_ctl;
    logic       lysis_waste_ctl;
    logic [1:0] beads_in_ctl;
    logic       bead_waste_ctl;
    logic [2:0] pump;
    logic       push_ctl;
    logic       sep_ctl;
    logic [1:0] sieve_ctl;
    logic       waste_ctl;

    modport master (
        output start, abort, stage_en,
        input  busy, done, aborted, phase,
        input  cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl,
        input  lysis_waste_ctl, beads_in_ctl, bead_waste_ctl, pump,
        input  push_ctl, sep_ctl, sieve_ctl, waste_ctl
    );

    modport slave (
        input  start, abort, stage_en,
        output busy, done, aborted, phase,
        output cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl,
        output lysis_waste_ctl, beads_in_ctl, bead_waste_ctl, pump,
        output push_ctl, sep_ctl, sieve_ctl, waste_ctl
    );

endinterface

// File: rtl/mrnaiso_pump_seq.sv
// Peristaltic pump driver: divider plus 6-step, 3-valve pattern generator.
// Latency: pump registered; restart shows step 0 on the next cycle.
// Backpressure: none; free-running while run is high.
// Ports: clk, rst (sync, active-high), run (pump active), restart
// (force step 0 this cycle), pump (3 valve lines, 111 when idle).
module mrnaiso_pump_seq
    import mrnaiso_ctl_pkg::*;
#(
    parameter int PUMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       restart,
    output logic [2:0] pump
);

    localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    pump_q, pump_d;

    always_comb begin
        div_d  = div_q;
        step_d = step_q;
        if (!run || restart) begin
            div_d  = '0;
            step_d = '0;
        end else if (div_q == DW'(PUMP_DIV - 1)) begin
            div_d  = '0;
            step_d = (step_q == 3'(PUMP_STEPS - 1)) ? 3'd0 : step_q + 3'd1;
        end else begin
            div_d = div_q + DW'(1);
        end
        pump_d = run ? PUMP_PATTERN[step_d] : PUMP_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            step_q <= '0;
            pump_q <= PUMP_IDLE;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            pump_q <= pump_d;
        end
    end

    assign pump = pump_q;

endmodule

// File: rtl/mrnaiso_ctl_sequencer.sv
// Valve sequencer for one mRNA isolation run: LOAD, LYSE, BIND, SEP, COLLECT.
// Latency: all outputs registered; accepted start shows LOAD on the next cycle.
// Backpressure: start ignored outside IDLE; abort drops to IDLE in one cycle.
// Ports: clk, rst (sync, active-high), bus (slave side: start/abort/stage_en
// in; busy/done/aborted/phase and all valve control lines out).
module mrnaiso_ctl_sequencer
    import mrnaiso_ctl_pkg::*;
#(
    parameter int T_LOAD    = 64,
    parameter int T_LYSE    = 256,
    parameter int T_BIND    = 256,
    parameter int T_SEP     = 128,
    parameter int T_COLLECT = 64,
    parameter int PUMP_DIV  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mrnaiso_ctl_sequencer_if.slave   bus
);

    localparam int TMAX_A = (T_LOAD > T_LYSE) ? T_LOAD : T_LYSE;
    localparam int TMAX_B = (T_BIND > T_SEP) ? T_BIND : T_SEP;
    localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMAX   = (TMAX_C > T_COLLECT) ? TMAX_C : T_COLLECT;
    // The counter is loaded with the full phase length, so a power-of-two
    // length needs one bit more than $clog2 of it.
    localparam int CW     = $clog2(TMAX + 1);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    en_q, en_d;
    logic          aborted_d;
    ctl_t          ctl_q;
    logic          busy_q, done_q, aborted_q;
    logic          pump_run, pump_restart;

    function automatic logic [CW-1:0] phase_len(phase_e ph);
        case (ph)
            PH_LOAD:    return CW'(T_LOAD);
            PH_LYSE:    return CW'(T_LYSE);
            PH_BIND:    return CW'(T_BIND);
            PH_SEP:     return CW'(T_SEP);
            PH_COLLECT: return CW'(T_COLLECT);
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        aborted_d = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                // Start wins over a simultaneous abort; an empty mask is no run.
                if (bus.start && (bus.stage_en != 4'b0000)) begin
                    phase_d = PH_LOAD;
                    cnt_d   = phase_len(PH_LOAD);
                    en_d    = bus.stage_en;
                end
            end
            PH_LOAD, PH_LYSE, PH_BIND, PH_SEP, PH_COLLECT: begin
                if (bus.abort) begin
                    phase_d   = PH_IDLE;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CW'(1)) begin
                    // Phase codes are consecutive, COLLECT+1 is DONE.
                    phase_d = phase_e'(phase_q + 3'd1);
                    cnt_d   = phase_len(phase_e'(phase_q + 3'd1));
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // DONE lasts one cycle; unused codes recover to IDLE.
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from next state so they line up with phase_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            en_q      <= '0;
            ctl_q     <= CTL_ALL_CLOSED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            ctl_q     <= ctl_decode(phase_d, en_d);
            busy_q    <= (phase_d != PH_IDLE) && (phase_d != PH_DONE);
            done_q    <= (phase_d == PH_DONE);
            aborted_q <= aborted_d;
        end
    end

    assign pump_run     = (phase_d == PH_LYSE) || (phase_d == PH_BIND);
    assign pump_restart = pump_run && (phase_d != phase_q);

    mrnaiso_pump_seq #(
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk     (clk),
        .rst     (rst),
        .run     (pump_run),
        .restart (pump_restart),
        .pump    (bus.pump)
    );

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.aborted         = aborted_q;
    assign bus.phase           = phase_q;
    assign bus.cells_in_ctl    = ctl_q.cells_in;
    assign bus.cells_out_ctl   = ctl_q.cells_out;
    assign bus.collect_ctl     = ctl_q.collect;
    assign bus.lysis_in_ctl    = ctl_q.lysis_in;
    assign bus.lysis_waste_ctl = ctl_q.lysis_waste;
    assign bus.beads_in_ctl    = ctl_q.beads_in;
    assign bus.bead_waste_ctl  = ctl_q.bead_waste;
    assign bus.push_ctl        = ctl_q.push;
    assign bus.sep_ctl         = ctl_q.sep;
    assign bus.sieve_ctl       = ctl_q.sieve;
    assign bus.waste_ctl       = ctl_q.waste;

endmodule

// File: tb/tb_mrnaiso_ctl_sequencer.sv
// Bench for the valve sequencer: directed runs with hand-computed expectations.
// Latency: expectations are tagged with the absolute cycle they apply to.
// Backpressure: n/a; done/aborted pulses are matched against an event queue.
module tb_mrnaiso_ctl_sequencer;

    localparam int S_BUSY = 0,  S_PHASE = 1,  S_CIN = 2,   S_COUT = 3;
    localparam int S_COLL = 4,  S_LYSIN = 5,  S_LYSW = 6,  S_BEADS = 7;
    localparam int S_BW   = 8,  S_PUMP = 9,   S_PUSH = 10, S_SEP = 11;
    localparam int S_SIEVE = 12, S_WASTE = 13, S_DONE = 14, S_ABT = 15;
    localparam int S_ALL  = 16;
    localparam logic [31:0] ALL1 = 32'h01FF_FFFF;
    localparam int EV_DONE = 1, EV_ABT = 2;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;

    exp_t exp_q[$];
    ev_t  ev_q[$];

    mrnaiso_ctl_sequencer_if bus ();

    mrnaiso_ctl_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] field(int sel);
        case (sel)
            S_BUSY:  return {31'd0, bus.busy};
            S_PHASE: return {29'd0, bus.phase};
            S_CIN:   return {28'd0, bus.cells_in_ctl};
            S_COUT:  return {28'd0, bus.cells_out_ctl};
            S_COLL:  return {28'd0, bus.collect_ctl};
            S_LYSIN: return {31'd0, bus.lysis_in_ctl};
            S_LYSW:  return {31'd0, bus.lysis_waste_ctl};
            S_BEADS: return {30'd0, bus.beads_in_ctl};
            S_BW:    return {31'd0, bus.bead_waste_ctl};
            S_PUMP:  return {29'd0, bus.pump};
            S_PUSH:  return {31'd0, bus.push_ctl};
            S_SEP:   return {31'd0, bus.sep_ctl};
            S_SIEVE: return {30'd0, bus.sieve_ctl};
            S_WASTE: return {31'd0, bus.waste_ctl};
            S_DONE:  return {31'd0, bus.done};
            S_ABT:   return {31'd0, bus.aborted};
            default: return {7'd0, bus.cells_in_ctl, bus.cells_out_ctl,
                             bus.collect_ctl, bus.lysis_in_ctl,
                             bus.lysis_waste_ctl, bus.beads_in_ctl,
                             bus.bead_waste_ctl, bus.pump, bus.push_ctl,
                             bus.sep_ctl, bus.sieve_ctl, bus.waste_ctl};
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            S_BUSY:  return "busy";
            S_PHASE: return "phase";
            S_CIN:   return "cells_in_ctl";
            S_COUT:  return "cells_out_ctl";
            S_COLL:  return "collect_ctl";
            S_LYSIN: return "lysis_in_ctl";
            S_LYSW:  return "lysis_waste_ctl";
            S_BEADS: return "beads_in_ctl";
            S_BW:    return "bead_waste_ctl";
            S_PUMP:  return "pump";
            S_PUSH:  return "push_ctl";
            S_SEP:   return "sep_ctl";
            S_SIEVE: return "sieve_ctl";
            S_WASTE: return "waste_ctl";
            S_DONE:  return "done";
            S_ABT:   return "aborted";
            default: return "all_lines";
        endcase
    endfunction

    // Keep the scoreboard ordered by cycle so the monitor only looks at the head.
    task automatic expect_at(input int c, input int sel, input logic [31:0] v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endtask

    task automatic expect_event(input int c, input int kind);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        ev_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops expectations due this cycle and matches status pulses.
    exp_t        m_e;
    ev_t         m_ev;
    logic [31:0] m_got;
    int          m_kind;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e   = exp_q.pop_front();
            m_got = field(m_e.sel);
            n_tests++;
            if (m_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d reached late at cycle %0d",
                         sel_name(m_e.sel), m_e.cyc, cyc);
            end else if (m_got !== m_e.val) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %0h expected %0h",
                         sel_name(m_e.sel), cyc, m_got, m_e.val);
            end
        end
        if (bus.done === 1'b1 || bus.aborted === 1'b1) begin
            m_kind = (bus.done === 1'b1) ? EV_DONE : EV_ABT;
            n_tests++;
            if (ev_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse @cyc %0d: got kind %0d expected no pulse",
                         cyc, m_kind);
            end else begin
                m_ev = ev_q.pop_front();
                if (m_ev.cyc != cyc || m_ev.kind != m_kind) begin
                    n_fail++;
                    $display("FAIL pulse: got kind %0d @cyc %0d expected kind %0d @cyc %0d",
                             m_kind, cyc, m_ev.kind, m_ev.cyc);
                end
            end
        end
        if (end_req && !end_done) begin
            n_tests++;
            if (exp_q.size() != 0 || ev_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d checks and %0d pulses pending expected 0 and 0",
                         exp_q.size(), ev_q.size());
            end
            end_done = 1'b1;
        end
    end

    int t, t2, s, u;

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.stage_en = 4'b0000;

        // Reset state after two clocks of rst.
        expect_at(2, S_ALL, ALL1);
        expect_at(2, S_BUSY, 0);
        expect_at(2, S_PHASE, 0);
        expect_at(2, S_DONE, 0);
        expect_at(2, S_ABT, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Run A: stages 1 and 3.
        t = cyc;
        bus.start    = 1'b1;
        bus.stage_en = 4'b0101;
        expect_at(t+1,   S_PHASE, 1);
        expect_at(t+1,   S_BUSY, 1);
        expect_at(t+1,   S_CIN, 4'b1010);
        expect_at(t+1,   S_WASTE, 0);
        expect_at(t+1,   S_PUMP, 3'b111);
        expect_at(t+64,  S_PHASE, 1);
        expect_at(t+65,  S_PHASE, 2);
        expect_at(t+65,  S_COUT, 4'b1010);
        expect_at(t+65,  S_LYSIN, 0);
        expect_at(t+65,  S_LYSW, 0);
        expect_at(t+65,  S_CIN, 4'b1111);
        expect_at(t+65,  S_PUMP, 3'b011);
        expect_at(t+68,  S_PUMP, 3'b011);
        expect_at(t+69,  S_PUMP, 3'b001);
        expect_at(t+73,  S_PUMP, 3'b101);
        expect_at(t+77,  S_PUMP, 3'b100);
        expect_at(t+81,  S_PUMP, 3'b110);
        expect_at(t+85,  S_PUMP, 3'b010);
        expect_at(t+89,  S_PUMP, 3'b011);
        expect_at(t+320, S_PUMP, 3'b100);
        expect_at(t+320, S_PHASE, 2);
        expect_at(t+321, S_PHASE, 3);
        expect_at(t+321, S_PUMP, 3'b011);
        expect_at(t+321, S_BEADS, 2'b00);
        expect_at(t+321, S_SIEVE, 2'b11);
        expect_at(t+325, S_PUMP, 3'b001);
        expect_at(t+577, S_PHASE, 4);
        expect_at(t+577, S_SEP, 0);
        expect_at(t+577, S_PUSH, 0);
        expect_at(t+577, S_WASTE, 0);
        expect_at(t+577, S_SIEVE, 2'b11);
        expect_at(t+577, S_PUMP, 3'b111);
        expect_at(t+577, S_BEADS, 2'b11);
        expect_at(t+705, S_PHASE, 5);
        expect_at(t+705, S_COLL, 4'b1010);
        expect_at(t+705, S_SIEVE, 2'b00);
        expect_at(t+705, S_PUSH, 0);
        expect_at(t+705, S_BW, 0);
        expect_at(t+705, S_SEP, 1);
        expect_at(t+768, S_COLL, 4'b1010);
        expect_at(t+769, S_PHASE, 6);
        expect_at(t+769, S_BUSY, 0);
        expect_at(t+769, S_ALL, ALL1);
        expect_at(t+770, S_PHASE, 0);
        expect_at(t+770, S_BUSY, 0);
        expect_event(t+769, EV_DONE);
        @(negedge clk);
        bus.start = 1'b0;

        // Start and abort in the DONE cycle are both ignored; start held
        // one more cycle is accepted (run B, stages 1 and 2).
        wait_cyc(t+769);
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        bus.stage_en = 4'b0011;
        t2 = t + 770;
        expect_at(t2+1,   S_PHASE, 1);
        expect_at(t2+1,   S_CIN, 4'b1100);
        expect_at(t2+1,   S_BUSY, 1);
        expect_at(t2+65,  S_COUT, 4'b1100);
        expect_at(t2+321, S_BEADS, 2'b10);
        expect_at(t2+321, S_SIEVE, 2'b11);
        expect_at(t2+705, S_SIEVE, 2'b10);
        expect_at(t2+705, S_COLL, 4'b1100);
        expect_at(t2+769, S_PHASE, 6);
        expect_event(t2+769, EV_DONE);
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(t2+10);
        bus.stage_en = 4'b1111;

        // Empty mask and lone abort in IDLE do nothing.
        wait_cyc(t2+772);
        s = cyc;
        bus.start    = 1'b1;
        bus.stage_en = 4'b0000;
        expect_at(s+1, S_PHASE, 0);
        expect_at(s+1, S_BUSY, 0);
        expect_at(s+2, S_PHASE, 0);
        expect_at(s+3, S_ABT, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);

        // Run C: start beats a simultaneous abort, then abort on BIND cycle 10.
        u = cyc;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        bus.stage_en = 4'b1000;
        expect_at(u+1,   S_PHASE, 1);
        expect_at(u+1,   S_CIN, 4'b0111);
        expect_at(u+1,   S_ABT, 0);
        expect_at(u+330, S_PHASE, 3);
        expect_at(u+331, S_PHASE, 0);
        expect_at(u+331, S_ALL, ALL1);
        expect_at(u+331, S_BUSY, 0);
        expect_at(u+332, S_ABT, 0);
        expect_at(u+332, S_PHASE, 0);
        expect_event(u+331, EV_ABT);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_cyc(u+330);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        // Run past where an unaborted run would have finished.
        wait_cyc(u+780);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
